// File: rtl/store_buffer_unit.sv
// Store buffer: aligns sb/sh/sw into byte lanes, queues them in a FIFO,
// and drains the FIFO to data memory one write at a time.
module store_buffer_unit #(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] MMIO_TOP0 = 8'h10,
   parameter logic [7:0] MMIO_TOP1 = 8'h11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid,
   input  logic [2:0]  st_funct3,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   output logic        st_fault,
   output logic        sb_empty,
   output logic        dmem_write,
   output logic [31:0] dmem_address,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wmask,
   input  logic        dmem_resp
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t        r_state, w_state_n;
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_fifo_addr [DEPTH];
   logic [31:0]   r_fifo_data [DEPTH];
   logic [3:0]    r_fifo_mask [DEPTH];
   logic          r_fault;
   logic          r_write, w_write_n;
   logic [31:0]   r_addr, w_addr_n;
   logic [31:0]   r_wdata, w_wdata_n;
   logic [3:0]    r_wmask, w_wmask_n;

   logic          w_mmio, w_bad, w_accept, w_push, w_pop;
   logic [1:0]    w_lo;
   logic [3:0]    w_mask;
   logic [31:0]   w_data, w_saddr;

   // MMIO targets see the store exactly as issued, without lane shifting
   assign w_mmio  = (st_addr[31:24] == MMIO_TOP0) ||
                    (st_addr[31:24] == MMIO_TOP1);
   assign w_lo    = w_mmio ? 2'b00 : st_addr[1:0];
   assign w_saddr = w_mmio ? st_addr : {st_addr[31:2], 2'b00};

   always_comb begin
      w_mask = 4'b0000;
      w_data = 32'd0;
      w_bad  = 1'b0;
      case (st_funct3)
         3'b000: begin
            w_mask = 4'b0001 << w_lo;
            w_data = {24'd0, st_data[7:0]} << {w_lo, 3'b000};
         end
         3'b001: begin
            w_bad  = w_lo[0];
            w_mask = 4'b0011 << w_lo;
            w_data = {16'd0, st_data[15:0]} << {w_lo, 3'b000};
         end
         3'b010: begin
            w_bad  = (w_lo != 2'b00);
            w_mask = 4'b1111;
            w_data = st_data;
         end
         default: w_bad = 1'b1;
      endcase
   end

   assign st_ready = (r_count != LP_FULL);
   assign w_accept = st_valid && st_ready;
   assign w_push   = w_accept && !w_bad;
   assign w_pop    = (r_state == S_ISSUE) && dmem_resp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_accept && w_bad;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wptr] <= w_saddr;
         r_fifo_data[r_wptr] <= w_data;
         r_fifo_mask[r_wptr] <= w_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_write <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_wmask <= 4'b0000;
      end else begin
         r_state <= w_state_n;
         r_write <= w_write_n;
         r_addr  <= w_addr_n;
         r_wdata <= w_wdata_n;
         r_wmask <= w_wmask_n;
      end
   end

   // Head stays in the FIFO until resp, so count covers the in-flight write
   always_comb begin
      w_state_n = r_state;
      w_write_n = r_write;
      w_addr_n  = r_addr;
      w_wdata_n = r_wdata;
      w_wmask_n = r_wmask;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_addr_n  = r_fifo_addr[r_rptr];
               w_wdata_n = r_fifo_data[r_rptr];
               w_wmask_n = r_fifo_mask[r_rptr];
               w_write_n = 1'b1;
               w_state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (dmem_resp) begin
               w_write_n = 1'b0;
               w_state_n = S_IDLE;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign st_fault     = r_fault;
   assign sb_empty     = (r_count == '0) && (r_state == S_IDLE);
   assign dmem_write   = r_write;
   assign dmem_address = r_addr;
   assign dmem_wdata   = r_wdata;
   assign dmem_wmask   = r_wmask;

endmodule
